// File: rtl/ipv6_pkt_gen_512_if.sv
// ipv6_pkt_gen_512_if: 512b Avalon-ST style stream between a packet source and its sink.
//   valid  source -> sink  beat present
//   ready  sink -> source  sink accepts the beat this cycle
//   sop    source -> sink  first beat of a packet
//   eop    source -> sink  last beat of a packet
//   error  source -> sink  beat carries an error (unused by the generator, always 0)
//   empty  source -> sink  unused bytes on the eop beat
//   data   source -> sink  beat payload, byte 0 in data[511:504]
interface ipv6_pkt_gen_512_if;
  logic         valid;
  logic         ready;
  logic         sop;
  logic         eop;
  logic         error;
  logic [5:0]   empty;
  logic [511:0] data;

  modport master (output valid, sop, eop, error, empty, data, input ready);
  modport slave  (input valid, sop, eop, error, empty, data, output ready);
endinterface

// File: rtl/ipv6_pkt_gen_512.sv
// ipv6_pkt_gen_512: traffic source for the 512b IPv6 parse path.
//   Emits bursts of packets: beat 0 = internal header (sop), beat 1 = IPv6 header
//   placed HDR_OFFSET bytes into the beat, beats 2.. = payload. Config is latched on i_start.
// Parameters:
//   NODE_ID     node index, only reported in elaboration parameter errors
//   SRC_ID      4b source id written into the internal header (0..15)
//   HDR_OFFSET  byte offset of the IPv6 header inside beat 1 (0..24)
//   GAP_CYCLES  idle cycles between packets (0 = back-to-back)
// Build option:
//   IPV6_GEN_LFSR_PAYLOAD_EN  payload = 16 copies of a 32b Galois LFSR (poly 32'h80200003,
//                             seed 32'hACE1_0001 at i_start, one step per payload beat).
//                             Undefined: payload = 16 copies of {pkt_idx, beat_idx}.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (aborts a packet in flight)
//   out             512b stream source (master modport)
//   i_start         one-cycle pulse, latches all i_* config and starts a burst
//   i_num_pkts      packets in the burst (0 -> o_done only)
//   i_pkt_beats     beats per packet including sop; values below 2 are treated as 2
//   i_last_empty    empty value on the eop beat
//   i_hop_limit, i_next_hdr, i_src_addr, i_dst_addr   IPv6 header fields (hop 0 passes through)
//   o_busy          burst in progress, up to and including the o_done cycle
//   o_done          one-cycle pulse at burst completion
//   o_pkt_cnt       packets whose eop was accepted in this burst (saturating)
module ipv6_pkt_gen_512 #(
  parameter int NODE_ID    = 4,
  parameter int SRC_ID     = 0,
  parameter int HDR_OFFSET = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ipv6_pkt_gen_512_if.master   out,
  input  logic                 i_start,
  input  logic [15:0]          i_num_pkts,
  input  logic [7:0]           i_pkt_beats,
  input  logic [5:0]           i_last_empty,
  input  logic [7:0]           i_hop_limit,
  input  logic [7:0]           i_next_hdr,
  input  logic [127:0]         i_src_addr,
  input  logic [127:0]         i_dst_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_pkt_cnt
);

  if (SRC_ID < 0 || SRC_ID > 15 || HDR_OFFSET < 0 || HDR_OFFSET > 24 || GAP_CYCLES < 0) begin : g_param_err
    $error("ipv6_pkt_gen_512 node %0d: SRC_ID/HDR_OFFSET/GAP_CYCLES out of range", NODE_ID);
  end

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_HDR, S_BODY, S_GAP} state_t;

  state_t         state, state_nxt;
  logic [15:0]    cfg_num;
  logic [7:0]     cfg_beats;
  logic [5:0]     cfg_empty;
  logic [7:0]     cfg_hop, cfg_nh;
  logic [127:0]   cfg_src, cfg_dst;
  logic [7:0]     beat_idx;
  logic [GW-1:0]  gap_cnt;
  logic           start_ok, beat_valid, xfer, last_beat, done_set;
  logic [15:0]    cnt_inc, plen;
  logic [319:0]   hdr_w;
  logic [511:0]   sop_data, hdr_data, body_data;
  logic           sop_c, eop_c;
  logic [5:0]     empty_c;
  logic [511:0]   data_c;

  assign start_ok   = (state == S_IDLE) && i_start && !o_busy;
  assign beat_valid = (state == S_SOP) || (state == S_HDR) || (state == S_BODY);
  assign xfer       = beat_valid && out.ready;
  // beat_idx is 1 on the header beat, so beats==2 makes the header beat the eop beat
  assign last_beat  = (beat_idx == cfg_beats - 8'd1);
  assign cnt_inc    = (o_pkt_cnt == 16'hFFFF) ? o_pkt_cnt : o_pkt_cnt + 16'd1;

  // 16b truncating arithmetic is intended: odd configs wrap rather than saturate
  assign plen = (({8'd0, cfg_beats} - 16'd1) << 6) - 16'(HDR_OFFSET) - 16'd40 - {10'd0, cfg_empty};

  assign hdr_w    = {4'h6, 8'h00, 20'h0_0000, plen, cfg_nh, cfg_hop, cfg_src, cfg_dst};
  assign hdr_data = {hdr_w, 192'd0} >> (HDR_OFFSET * 8);

  always_comb begin
    sop_data          = '0;
    sop_data[510-:4]  = 4'(SRC_ID);
    sop_data[478-:7]  = 7'(HDR_OFFSET);
  end

`ifdef IPV6_GEN_LFSR_PAYLOAD_EN
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  logic [31:0] lfsr;
  assign body_data = {16{lfsr}};
`else
  // o_pkt_cnt doubles as the index of the packet in flight
  assign body_data = {16{o_pkt_cnt, 8'd0, beat_idx}};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    sop_c     = 1'b0;
    eop_c     = 1'b0;
    empty_c   = '0;
    data_c    = '0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (i_num_pkts == 16'd0) done_set  = 1'b1;
          else                     state_nxt = S_SOP;
        end
      end
      S_SOP: begin
        sop_c  = 1'b1;
        data_c = sop_data;
        if (xfer) state_nxt = S_HDR;
      end
      S_HDR, S_BODY: begin
        eop_c   = last_beat;
        empty_c = last_beat ? cfg_empty : 6'd0;
        data_c  = (state == S_HDR) ? hdr_data : body_data;
        if (xfer) begin
          if (!last_beat) begin
            state_nxt = S_BODY;
          end else if (GAP_CYCLES != 0) begin
            state_nxt = S_GAP;
          end else if (cnt_inc < cfg_num) begin
            // zero gap: decide on the count this eop is about to produce
            state_nxt = S_SOP;
          end else begin
            state_nxt = S_IDLE;
            done_set  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (o_pkt_cnt < cfg_num) state_nxt = S_SOP;
          else begin
            state_nxt = S_IDLE;
            done_set  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_num   <= '0;
      cfg_beats <= 8'd2;
      cfg_empty <= '0;
      cfg_hop   <= '0;
      cfg_nh    <= '0;
      cfg_src   <= '0;
      cfg_dst   <= '0;
      beat_idx  <= '0;
      gap_cnt   <= '0;
      o_pkt_cnt <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
`ifdef IPV6_GEN_LFSR_PAYLOAD_EN
      lfsr      <= LFSR_SEED;
`endif
    end else begin
      o_done  <= done_set;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (start_ok) begin
        cfg_num   <= i_num_pkts;
        cfg_beats <= (i_pkt_beats < 8'd2) ? 8'd2 : i_pkt_beats;
        cfg_empty <= i_last_empty;
        cfg_hop   <= i_hop_limit;
        cfg_nh    <= i_next_hdr;
        cfg_src   <= i_src_addr;
        cfg_dst   <= i_dst_addr;
        beat_idx  <= '0;
        o_pkt_cnt <= '0;
        o_busy    <= (i_num_pkts != 16'd0);
`ifdef IPV6_GEN_LFSR_PAYLOAD_EN
        lfsr      <= LFSR_SEED;
`endif
      end else begin
        if (o_done) o_busy <= 1'b0;
        if (xfer) begin
          beat_idx <= eop_c ? 8'd0 : beat_idx + 8'd1;
          if (eop_c) o_pkt_cnt <= cnt_inc;
`ifdef IPV6_GEN_LFSR_PAYLOAD_EN
          // right-shifting Galois form: feedback applied when bit 0 shifts out
          if (state == S_BODY) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'd0);
`endif
        end
      end
    end
  end

  assign out.valid = beat_valid;
  assign out.sop   = sop_c;
  assign out.eop   = eop_c;
  assign out.error = 1'b0;
  assign out.empty = empty_c;
  assign out.data  = data_c;

endmodule

// File: tb/tb_ipv6_pkt_gen_512.sv
module tb_ipv6_pkt_gen_512;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start0 = 1'b0, start1 = 1'b0;
  logic [15:0]  num = '0;
  logic [7:0]   beats = '0, hop = '0, nh = '0;
  logic [5:0]   empty = '0;
  logic [127:0] src = 128'h2001_0db8_0000_0001_0000_0000_0000_00a1;
  logic [127:0] dst = 128'hfe80_0000_0000_0000_0211_22ff_fe33_4455;
  logic         ready0 = 1'b0, ready1 = 1'b0;
  logic         busy0, busy1, done0, done1;
  logic [15:0]  cnt0, cnt1;

  ipv6_pkt_gen_512_if if0();
  ipv6_pkt_gen_512_if if1();
  assign if0.ready = ready0;
  assign if1.ready = ready1;

  ipv6_pkt_gen_512 #(.NODE_ID(1), .SRC_ID(5), .HDR_OFFSET(0), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst), .out(if0), .i_start(start0), .i_num_pkts(num),
    .i_pkt_beats(beats), .i_last_empty(empty), .i_hop_limit(hop), .i_next_hdr(nh),
    .i_src_addr(src), .i_dst_addr(dst), .o_busy(busy0), .o_done(done0), .o_pkt_cnt(cnt0));

  ipv6_pkt_gen_512 #(.NODE_ID(2), .SRC_ID(9), .HDR_OFFSET(24), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(rst), .out(if1), .i_start(start1), .i_num_pkts(num),
    .i_pkt_beats(beats), .i_last_empty(empty), .i_hop_limit(hop), .i_next_hdr(nh),
    .i_src_addr(src), .i_dst_addr(dst), .o_busy(busy1), .o_done(done1), .o_pkt_cnt(cnt1));

  typedef struct {
    logic [511:0] data;
    logic         sop, eop, err;
    logic [5:0]   empty;
    int           cyc;
  } beat_t;

  beat_t cap0[$], cap1[$];
  int cyc = 0, done0_cyc = 0, done1_cyc = 0, done0_n = 0, done1_n = 0;
  int nvec = 0, nbad = 0;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  // Records accepted beats and o_done pulses, using pre-edge values.
  always @(posedge clk) begin
    beat_t b;
    cyc = cyc + 1;
    if (if0.valid && if0.ready) begin
      b.data = if0.data; b.sop = if0.sop; b.eop = if0.eop; b.err = if0.error;
      b.empty = if0.empty; b.cyc = cyc;
      cap0.push_back(b);
    end
    if (if1.valid && if1.ready) begin
      b.data = if1.data; b.sop = if1.sop; b.eop = if1.eop; b.err = if1.error;
      b.empty = if1.empty; b.cyc = cyc;
      cap1.push_back(b);
    end
    if (done0) begin done0_cyc = cyc; done0_n = done0_n + 1; end
    if (done1) begin done1_cyc = cyc; done1_n = done1_n + 1; end
  end

  function automatic logic [511:0] exp_sop(input int sid, input int off);
    logic [511:0] d = '0;
    d[510-:4] = sid[3:0];
    d[478-:7] = off[6:0];
    return d;
  endfunction

  function automatic logic [511:0] exp_hdr(input int off, input int nb, input int emp,
      input logic [7:0] nhv, input logic [7:0] hv, input logic [127:0] s, input logic [127:0] dd);
    logic [511:0] d = '0;
    int b = 511 - off * 8;
    logic [15:0] pl = 16'((nb - 1) * 64 - off - 40 - emp);
    d[b-:4]       = 4'h6;
    d[b-32-:16]   = pl;
    d[b-48-:8]    = nhv;
    d[b-56-:8]    = hv;
    d[b-64-:128]  = s;
    d[b-192-:128] = dd;
    return d;
  endfunction

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [511:0] exp_body(input int p, input int b, input logic [31:0] l);
    logic [31:0] w = {p[15:0], b[15:0]};
`ifdef IPV6_GEN_LFSR_PAYLOAD_EN
    w = l;
`endif
    return {16{w}};
  endfunction

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic pulse1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (if0.valid !== 1'b0) begin nbad++; $display("FAIL rst_valid got %b want 0", if0.valid); end
    nvec++; if ({if0.sop, if0.eop, if0.error, if0.empty} !== 9'd0) begin nbad++; $display("FAIL rst_flags got %h want 0", {if0.sop, if0.eop, if0.error, if0.empty}); end
    nvec++; if (if0.data !== 512'd0) begin nbad++; $display("FAIL rst_data got %h want 0", if0.data); end
    nvec++; if ({busy0, done0, cnt0} !== 18'd0) begin nbad++; $display("FAIL rst_status got %h want 0", {busy0, done0, cnt0}); end
    nvec++; if (if1.valid !== 1'b0) begin nbad++; $display("FAIL rst_valid1 got %b want 0", if1.valid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (if0.valid !== 1'b0) begin nbad++; $display("FAIL idle_valid got %b want 0", if0.valid); end
  endtask

  task automatic test_basic();
    int n0 = done0_n;
    num = 16'd1; beats = 8'd3; hop = 8'd64; nh = 8'h11; empty = 6'd4;
    ready0 = 1'b1; cap0.delete();
    pulse0();
    nvec++; if (busy0 !== 1'b1) begin nbad++; $display("FAIL basic_busy got %b want 1", busy0); end
    for (int i = 0; i < 50 && done0_n == n0; i++) @(negedge clk);
    nvec++; if (done0_n != n0 + 1) begin nbad++; $display("FAIL basic_done got %0d want %0d", done0_n, n0 + 1); end
    nvec++; if (cap0.size() != 3) begin nbad++; $display("FAIL basic_nbeats got %0d want 3", cap0.size()); end
    if (cap0.size() == 3) begin
      nvec++; if ({cap0[0].sop, cap0[0].eop, cap0[0].empty} !== {2'b10, 6'd0}) begin nbad++; $display("FAIL basic_sop_flags got %h want %h", {cap0[0].sop, cap0[0].eop, cap0[0].empty}, {2'b10, 6'd0}); end
      nvec++; if (cap0[0].data !== exp_sop(5, 0)) begin nbad++; $display("FAIL basic_sop_data got %h want %h", cap0[0].data, exp_sop(5, 0)); end
      nvec++; if (cap0[1].data[511-48-:8] !== 8'h11) begin nbad++; $display("FAIL basic_nh got %h want 11", cap0[1].data[511-48-:8]); end
      nvec++; if (cap0[1].data[511-56-:8] !== 8'd64) begin nbad++; $display("FAIL basic_hop got %0d want 64", cap0[1].data[511-56-:8]); end
      nvec++; if (cap0[1].data !== exp_hdr(0, 3, 4, 8'h11, 8'd64, src, dst)) begin nbad++; $display("FAIL basic_hdr got %h want %h", cap0[1].data, exp_hdr(0, 3, 4, 8'h11, 8'd64, src, dst)); end
      nvec++; if ({cap0[1].sop, cap0[1].eop, cap0[1].empty} !== 8'd0) begin nbad++; $display("FAIL basic_hdr_flags got %h want 0", {cap0[1].sop, cap0[1].eop, cap0[1].empty}); end
      nvec++; if ({cap0[2].sop, cap0[2].eop, cap0[2].err, cap0[2].empty} !== {3'b010, 6'd4}) begin nbad++; $display("FAIL basic_eop_flags got %h want %h", {cap0[2].sop, cap0[2].eop, cap0[2].err, cap0[2].empty}, {3'b010, 6'd4}); end
      nvec++; if (cap0[2].data !== exp_body(0, 2, SEED)) begin nbad++; $display("FAIL basic_payload got %h want %h", cap0[2].data, exp_body(0, 2, SEED)); end
      nvec++; if (done0_cyc - cap0[2].cyc != 2) begin nbad++; $display("FAIL basic_done_lat got %0d want 2", done0_cyc - cap0[2].cyc); end
    end
    nvec++; if (cnt0 !== 16'd1) begin nbad++; $display("FAIL basic_cnt got %0d want 1", cnt0); end
    nvec++; if ({busy0, done0} !== 2'b00) begin nbad++; $display("FAIL basic_after got %b want 00", {busy0, done0}); end
  endtask

  // HDR_OFFSET=24, zero gap; i_pkt_beats=1 is clamped to 2 so the header beat is eop.
  task automatic test_offset_b2b();
    int n1 = done1_n;
    num = 16'd2; beats = 8'd1; hop = 8'd0; nh = 8'h06; empty = 6'd0;
    ready1 = 1'b1; cap1.delete();
    pulse1();
    for (int i = 0; i < 50 && done1_n == n1; i++) @(negedge clk);
    nvec++; if (done1_n != n1 + 1) begin nbad++; $display("FAIL off_done got %0d want %0d", done1_n, n1 + 1); end
    nvec++; if (cap1.size() != 4) begin nbad++; $display("FAIL off_nbeats got %0d want 4", cap1.size()); end
    if (cap1.size() == 4) begin
      nvec++; if (cap1[0].data !== exp_sop(9, 24)) begin nbad++; $display("FAIL off_sop_data got %h want %h", cap1[0].data, exp_sop(9, 24)); end
      nvec++; if ({cap1[1].sop, cap1[1].eop, cap1[1].empty} !== {2'b01, 6'd0}) begin nbad++; $display("FAIL off_hdr_eop got %h want %h", {cap1[1].sop, cap1[1].eop, cap1[1].empty}, {2'b01, 6'd0}); end
      nvec++; if (cap1[1].data[287-:16] !== 16'd0) begin nbad++; $display("FAIL off_plen got %h want 0", cap1[1].data[287-:16]); end
      nvec++; if (cap1[1].data[127:0] !== dst) begin nbad++; $display("FAIL off_dst got %h want %h", cap1[1].data[127:0], dst); end
      nvec++; if (cap1[1].data !== exp_hdr(24, 2, 0, 8'h06, 8'd0, src, dst)) begin nbad++; $display("FAIL off_hdr got %h want %h", cap1[1].data, exp_hdr(24, 2, 0, 8'h06, 8'd0, src, dst)); end
      nvec++; if (cap1[2].cyc - cap1[1].cyc != 1 || cap1[2].sop !== 1'b1) begin nbad++; $display("FAIL off_b2b got gap %0d sop %b want 1 1", cap1[2].cyc - cap1[1].cyc, cap1[2].sop); end
      nvec++; if (done1_cyc - cap1[3].cyc != 1) begin nbad++; $display("FAIL off_done_lat got %0d want 1", done1_cyc - cap1[3].cyc); end
    end
    nvec++; if (cnt1 !== 16'd2) begin nbad++; $display("FAIL off_cnt got %0d want 2", cnt1); end
  endtask

  task automatic test_backpressure();
    int n0 = done0_n;
    int nstall = 0;
    logic sv_v, sv_r, sv_sop, sv_eop;
    logic [5:0] sv_emp;
    logic [511:0] sv_d;
    logic [31:0] ml = SEED;
    logic [511:0] ex;
    num = 16'd3; beats = 8'd3; hop = 8'd5; nh = 8'h06; empty = 6'd2;
    ready0 = 1'b0; cap0.delete();
    pulse0();
    hop = 8'hFF; nh = 8'h3A; empty = 6'd9;   // must not affect the running burst
    sv_v = 1'b0; sv_r = 1'b0; sv_sop = 1'b0; sv_eop = 1'b0; sv_emp = '0; sv_d = '0;
    for (int i = 0; i < 200 && done0_n == n0; i++) begin
      if (sv_v && !sv_r) begin
        nstall++;
        nvec++; if ({if0.valid, if0.sop, if0.eop, if0.empty, if0.data} !== {1'b1, sv_sop, sv_eop, sv_emp, sv_d}) begin
          nbad++; $display("FAIL bp_stable got v%b s%b e%b %h want held", if0.valid, if0.sop, if0.eop, if0.data);
        end
      end
      ready0 = ~ready0;
      sv_v = if0.valid; sv_r = ready0; sv_sop = if0.sop; sv_eop = if0.eop; sv_emp = if0.empty; sv_d = if0.data;
      @(negedge clk);
    end
    ready0 = 1'b1;
    nvec++; if (done0_n != n0 + 1) begin nbad++; $display("FAIL bp_done got %0d want %0d", done0_n, n0 + 1); end
    nvec++; if (nstall == 0) begin nbad++; $display("FAIL bp_stalls got 0 want >0"); end
    nvec++; if (cap0.size() != 9) begin nbad++; $display("FAIL bp_nbeats got %0d want 9", cap0.size()); end
    for (int i = 0; i < cap0.size() && i < 9; i++) begin
      if (i % 3 == 0)      ex = exp_sop(5, 0);
      else if (i % 3 == 1) ex = exp_hdr(0, 3, 2, 8'h06, 8'd5, src, dst);
      else begin ex = exp_body(i / 3, 2, ml); ml = lfsr_nx(ml); end
      nvec++; if (cap0[i].data !== ex || cap0[i].eop !== (i % 3 == 2) || cap0[i].sop !== (i % 3 == 0)) begin
        nbad++; $display("FAIL bp_beat%0d got %h want %h", i, cap0[i].data, ex);
      end
    end
    nvec++; if (cnt0 !== 16'd3) begin nbad++; $display("FAIL bp_cnt got %0d want 3", cnt0); end
  endtask

  task automatic test_zero_pkts();
    int n0 = done0_n;
    logic seen = 1'b0;
    num = 16'd0; beats = 8'd3; ready0 = 1'b1;
    pulse0();
    nvec++; if ({done0, busy0, if0.valid} !== 3'b100) begin nbad++; $display("FAIL zero_first got %b want 100", {done0, busy0, if0.valid}); end
    @(negedge clk);
    nvec++; if (done0 !== 1'b0) begin nbad++; $display("FAIL zero_pulse got %b want 0", done0); end
    for (int i = 0; i < 5; i++) begin
      if (if0.valid || busy0) seen = 1'b1;
      @(negedge clk);
    end
    nvec++; if (seen !== 1'b0) begin nbad++; $display("FAIL zero_quiet got %b want 0", seen); end
    nvec++; if (done0_n != n0 + 1) begin nbad++; $display("FAIL zero_ndone got %0d want %0d", done0_n, n0 + 1); end
  endtask

  task automatic test_reset_mid();
    int n0;
    num = 16'd4; beats = 8'd4; hop = 8'd7; nh = 8'h11; empty = 6'd0;
    ready0 = 1'b1; cap0.delete();
    pulse0();
    for (int i = 0; i < 100 && cap0.size() < 7; i++) @(negedge clk);
    nvec++; if (cap0.size() != 7 || cnt0 !== 16'd1) begin nbad++; $display("FAIL mid_progress got %0d beats cnt %0d want 7 1", cap0.size(), cnt0); end
    rst = 1'b1;
    #1;
    nvec++; if ({if0.valid, if0.eop, busy0, cnt0} !== 19'd0) begin nbad++; $display("FAIL mid_abort got %h want 0", {if0.valid, if0.eop, busy0, cnt0}); end
    @(negedge clk) rst = 1'b0;
    cap0.delete();
    n0 = done0_n;
    num = 16'd1; beats = 8'd3; empty = 6'd1;
    pulse0();
    for (int i = 0; i < 50 && done0_n == n0; i++) @(negedge clk);
    nvec++; if (cap0.size() != 3) begin nbad++; $display("FAIL mid_fresh_n got %0d want 3", cap0.size()); end
    if (cap0.size() == 3) begin
      nvec++; if (cap0[0].sop !== 1'b1 || cap0[0].data !== exp_sop(5, 0)) begin nbad++; $display("FAIL mid_fresh_sop got %b %h", cap0[0].sop, cap0[0].data); end
      nvec++; if (cap0[2].data !== exp_body(0, 2, SEED) || cap0[2].empty !== 6'd1) begin nbad++; $display("FAIL mid_fresh_body got %h want %h", cap0[2].data, exp_body(0, 2, SEED)); end
    end
    nvec++; if (cnt0 !== 16'd1) begin nbad++; $display("FAIL mid_fresh_cnt got %0d want 1", cnt0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset_b2b();
    test_backpressure();
    test_zero_pkts();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
